// File: rtl/seven_seg_capture.sv
// Recovers a 4-digit hex word from a multiplexed, active-low seven-segment bus.
// A digit is committed once its {anode, segment} pattern has been stable long enough.
module seven_seg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] word_out,
    output logic [3:0]  dp_out,
    output logic [3:0]  digit_err,
    output logic        word_valid
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_M1  = 8'(STABLE_CYCLES - 1);

    logic [11:0] r_sample;
    logic [7:0]  r_count;
    logic [3:0]  r_captured;
    logic [3:0]  r_nib [4];
    logic [3:0]  r_dp;
    logic [3:0]  r_err;

    logic [11:0] w_in;
    logic        w_same;
    logic [3:0]  w_sel;
    logic        w_sel_valid;
    logic        w_commit;
    logic        w_complete;
    logic [3:0]  w_dec_nib;
    logic        w_dec_err;
    logic [3:0]  w_nib_next [4];
    logic [15:0] w_word_next;
    logic [3:0]  w_dp_next;
    logic [3:0]  w_err_next;

    assign w_in        = {an_in, seg_in};
    assign w_same      = (w_in == r_sample);
    assign w_sel       = ~an_in;
    assign w_sel_valid = (w_sel != 4'd0) && ((w_sel & (w_sel - 4'd1)) == 4'd0);
    assign w_commit    = w_same && (r_count == STABLE_M1) && w_sel_valid;
    assign w_complete  = w_commit && ((r_captured | w_sel) == 4'hF);

    // Segment lines are active-low; DP (bit 7) never influences the nibble.
    always_comb begin
        w_dec_nib = 4'h0;
        w_dec_err = 1'b0;
        case (seg_in[6:0])
            7'h40: w_dec_nib = 4'h0;
            7'h79: w_dec_nib = 4'h1;
            7'h24: w_dec_nib = 4'h2;
            7'h30: w_dec_nib = 4'h3;
            7'h19: w_dec_nib = 4'h4;
            7'h12: w_dec_nib = 4'h5;
            7'h02: w_dec_nib = 4'h6;
            7'h78: w_dec_nib = 4'h7;
            7'h00: w_dec_nib = 4'h8;
            7'h10: w_dec_nib = 4'h9;
            7'h08: w_dec_nib = 4'hA;
            7'h03: w_dec_nib = 4'hB;
            7'h46: w_dec_nib = 4'hC;
            7'h21: w_dec_nib = 4'hD;
            7'h06: w_dec_nib = 4'hE;
            7'h0E: w_dec_nib = 4'hF;
            default: w_dec_err = 1'b1;
        endcase
    end

    // Slot contents with the digit being committed this edge bypassed in.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign w_nib_next[gi]         = w_sel[gi] ? w_dec_nib  : r_nib[gi];
            assign w_dp_next[gi]          = w_sel[gi] ? ~seg_in[7] : r_dp[gi];
            assign w_err_next[gi]         = w_sel[gi] ? w_dec_err  : r_err[gi];
            assign w_word_next[4*gi +: 4] = w_nib_next[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample   <= 12'hFFF;
            r_count    <= 8'd0;
            r_captured <= 4'h0;
            r_dp       <= 4'h0;
            r_err      <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                r_nib[i] <= 4'h0;
            end
            word_out   <= 16'h0000;
            dp_out     <= 4'h0;
            digit_err  <= 4'h0;
            word_valid <= 1'b0;
        end else begin
            r_sample   <= w_in;
            word_valid <= 1'b0;
            if (!w_same) begin
                r_count <= 8'd1;
            end else if (r_count != STABLE_MAX) begin
                r_count <= r_count + 8'd1;
            end

            if (w_commit) begin
                for (int i = 0; i < 4; i++) begin
                    r_nib[i] <= w_nib_next[i];
                end
                r_dp  <= w_dp_next;
                r_err <= w_err_next;
                if (w_complete) begin
                    r_captured <= 4'h0;
                    word_out   <= w_word_next;
                    dp_out     <= w_dp_next;
                    digit_err  <= w_err_next;
                    word_valid <= 1'b1;
                end else begin
                    r_captured <= r_captured | w_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed and randomized bench for seven_seg_capture, checked every cycle
// against a run-length based reference model.
module tb_seven_seg_capture;

    localparam int STABLE = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] word_out;
    logic [3:0]  dp_out;
    logic [3:0]  digit_err;
    logic        word_valid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    seven_seg_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .an_in     (an_in),
        .word_out  (word_out),
        .dp_out    (dp_out),
        .digit_err (digit_err),
        .word_valid(word_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: run length of identical samples, captured set, slot arrays.
    localparam logic [6:0] CODES [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [11:0] m_prev;
    int          m_run;
    bit          m_cap [4];
    logic [3:0]  m_nib [4];
    bit          m_dp  [4];
    bit          m_err [4];
    logic [15:0] exp_word;
    logic [3:0]  exp_dp;
    logic [3:0]  exp_err;
    logic        exp_valid;

    task automatic model_reset();
        m_prev = 12'hFFF;
        m_run = 0;
        for (int i = 0; i < 4; i++) begin
            m_cap[i] = 0; m_nib[i] = 4'h0; m_dp[i] = 0; m_err[i] = 0;
        end
        exp_word = 16'h0; exp_dp = 4'h0; exp_err = 4'h0; exp_valid = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] an, input logic [7:0] seg);
        int idx;
        bit all;
        exp_valid = 1'b0;
        if ({an, seg} == m_prev) m_run = m_run + 1;
        else m_run = 1;
        m_prev = {an, seg};
        if (m_run == STABLE && $countones(~an) == 1) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (!an[k]) idx = k;
            m_nib[idx] = 4'h0;
            m_err[idx] = 1;
            for (int k = 0; k < 16; k++) begin
                if (CODES[k] == seg[6:0]) begin
                    m_nib[idx] = 4'(k);
                    m_err[idx] = 0;
                end
            end
            m_dp[idx] = (seg[7] == 1'b0);
            m_cap[idx] = 1;
            all = m_cap[0] && m_cap[1] && m_cap[2] && m_cap[3];
            if (all) begin
                for (int k = 0; k < 4; k++) begin
                    exp_word[4*k +: 4] = m_nib[k];
                    exp_dp[k]  = m_dp[k];
                    exp_err[k] = m_err[k];
                    m_cap[k]   = 0;
                end
                exp_valid = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("word_valid", {31'd0, word_valid}, {31'd0, exp_valid});
        chk("word_out", {16'd0, word_out}, {16'd0, exp_word});
        chk("dp_out", {28'd0, dp_out}, {28'd0, exp_dp});
        chk("digit_err", {28'd0, digit_err}, {28'd0, exp_err});
        if (word_valid === 1'b1) pulses++;
    endtask

    // Called at a falling edge: apply inputs, clock once, check after the edge.
    task automatic step(input logic [3:0] an, input logic [7:0] seg);
        an_in = an;
        seg_in = seg;
        @(posedge clk);
        model_edge(an, seg);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        for (int i = 0; i < n; i++) step(an, seg);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b1;
            an_in = 4'($urandom);
            seg_in = 8'($urandom);
            @(posedge clk);
            model_reset();
            #1;
            check_outputs();
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    int p0;
    logic [3:0] r_an;
    logic [7:0] r_seg;

    initial begin
        rst = 1'b1;
        an_in = 4'hF;
        seg_in = 8'hFF;
        model_reset();
        @(negedge clk);

        // Reset with arbitrary inputs
        do_reset(2);
        chk("reset_word", {16'd0, word_out}, 32'h0);
        chk("reset_pulses", pulses, 0);

        // Full scan -> 4321
        p0 = pulses;
        hold(4'hE, 8'hF9, 4);
        hold(4'hD, 8'hA4, 4);
        hold(4'hB, 8'hB0, 4);
        hold(4'h7, 8'h99, 3);
        chk("scan_no_early_pulse", pulses - p0, 0);
        step(4'h7, 8'h99);
        chk("scan_pulse_on_4th_edge", {31'd0, word_valid}, 32'd1);
        chk("scan_word", {16'd0, word_out}, 32'h4321);
        chk("scan_dp", {28'd0, dp_out}, 32'h0);
        chk("scan_err", {28'd0, digit_err}, 32'h0);

        // Glitch rejection, then a long hold commits once
        p0 = pulses;
        hold(4'hE, 8'hC0, 3);
        hold(4'hD, 8'hC0, 3);
        hold(4'hB, 8'hC0, 3);
        hold(4'h7, 8'hC0, 3);
        chk("glitch_no_pulse", pulses - p0, 0);
        hold(4'hE, 8'hC0, 4);
        hold(4'hD, 8'hC0, 4);
        hold(4'hB, 8'hC0, 4);
        hold(4'h7, 8'hC0, 20);
        chk("long_hold_one_pulse", pulses - p0, 1);

        // Illegal pattern on digit 2, DP lit on digit 0
        p0 = pulses;
        hold(4'hE, 8'h40, 4);
        hold(4'hD, 8'hF9, 4);
        hold(4'hB, 8'hFF, 4);
        hold(4'h7, 8'hA4, 4);
        chk("illegal_pulse", pulses - p0, 1);
        chk("illegal_word", {16'd0, word_out}, 32'h2010);
        chk("illegal_err", {28'd0, digit_err}, 32'h4);
        chk("illegal_dp", {28'd0, dp_out}, 32'h1);

        // Invalid selects commit nothing and keep partial captures
        p0 = pulses;
        hold(4'hE, 8'hC0, 4);
        hold(4'hD, 8'hF9, 4);
        hold(4'hF, 8'hC0, 10);
        hold(4'b0011, 8'hC0, 10);
        chk("invalid_sel_no_pulse", pulses - p0, 0);
        hold(4'hB, 8'hB0, 4);
        hold(4'h7, 8'h99, 4);
        chk("invalid_sel_then_pulse", pulses - p0, 1);
        chk("invalid_sel_word", {16'd0, word_out}, 32'h4310);

        // Reset mid-scan discards partial captures
        hold(4'hE, 8'h90, 4);
        hold(4'hD, 8'h88, 4);
        do_reset(1);
        p0 = pulses;
        hold(4'hE, 8'h90, 4);
        hold(4'hD, 8'h88, 4);
        hold(4'hB, 8'h83, 4);
        chk("midreset_no_early", pulses - p0, 0);
        hold(4'h7, 8'hC6, 4);
        chk("midreset_pulse", pulses - p0, 1);
        chk("midreset_word", {16'd0, word_out}, 32'hCBA9);

        // Randomized traffic against the model
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset(1);
            end else begin
                case ($urandom_range(0, 9))
                    0:       r_an = 4'hF;
                    1:       r_an = 4'($urandom);
                    default: r_an = ~(4'b0001 << $urandom_range(0, 3));
                endcase
                if ($urandom_range(0, 3) == 0) r_seg = 8'($urandom);
                else r_seg = {1'($urandom), CODES[$urandom_range(0, 15)]};
                hold(r_an, r_seg, $urandom_range(1, 6));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
